// File: rtl/uart_batch_ctrl.sv
// Receive-then-echo sequencer: buffers UART RX bytes into an external RAM.
// It then replays each completed (or idle-flushed) batch to the transmitter.
module uart_batch_ctrl #(
    parameter int ADDR_W      = 14,
    parameter int BATCH_LEN   = 10000,
    parameter int TIMEOUT_CYC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [7:0]        mem_rdata,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              data_send_run,
    output logic              batch_done,
    output logic              overrun,
    output logic [15:0]       batch_cnt
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BATCH_LEN - 1);
    localparam logic [CNT_W-1:0]  FULL_LEN  = CNT_W'(BATCH_LEN);
    localparam logic [IDLE_W-1:0] IDLE_ONE  = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [1:0] {
        ST_RX,
        ST_RD,
        ST_TX,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]   send_len_q, send_len_d;
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               run_q, run_d;
    logic               ovr_q, ovr_d;
    logic [15:0]        bcnt_q, bcnt_d;
    logic [7:0]         txd_q, txd_d;
    logic               tx_first_q, tx_first_d;

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        send_len_d = send_len_q;
        idle_cnt_d = idle_cnt_q;
        run_d      = run_q;
        ovr_d      = ovr_q;
        bcnt_d     = bcnt_q;
        txd_d      = txd_q;
        tx_first_d = tx_first_q;

        if (rx_valid && (state_q != ST_RX)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_RX: begin
                if (rx_valid) begin
                    wr_cnt_d   = wr_cnt_q + CNT_ONE;
                    idle_cnt_d = '0;
                    if (wr_cnt_q == LAST_IDX) begin
                        send_len_d = FULL_LEN;
                        run_d      = 1'b1;
                        state_d    = ST_RD;
                    end
                end else if ((TIMEOUT_CYC != 0) && (wr_cnt_q != '0)) begin
                    idle_cnt_d = idle_cnt_q + IDLE_ONE;
                    if (idle_cnt_q == IDLE_LAST) begin
                        send_len_d = wr_cnt_q;
                        idle_cnt_d = '0;
                        run_d      = 1'b1;
                        state_d    = ST_RD;
                    end
                end
            end
            ST_RD: begin
                tx_first_d = 1'b1;
                state_d    = ST_TX;
            end
            ST_TX: begin
                // RAM data is only valid on the first TX cycle; hold it afterwards.
                tx_first_d = 1'b0;
                if (tx_first_q) begin
                    txd_d = mem_rdata;
                end
                if (tx_ready) begin
                    rd_cnt_d = rd_cnt_q + CNT_ONE;
                    if ((rd_cnt_q + CNT_ONE) == send_len_q) begin
                        run_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: begin
                bcnt_d     = bcnt_q + 16'd1;
                wr_cnt_d   = '0;
                rd_cnt_d   = '0;
                idle_cnt_d = '0;
                state_d    = ST_RX;
            end
            default: begin
                state_d = ST_RX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RX;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            send_len_q <= '0;
            idle_cnt_q <= '0;
            run_q      <= 1'b0;
            ovr_q      <= 1'b0;
            bcnt_q     <= '0;
            txd_q      <= '0;
            tx_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            send_len_q <= send_len_d;
            idle_cnt_q <= idle_cnt_d;
            run_q      <= run_d;
            ovr_q      <= ovr_d;
            bcnt_q     <= bcnt_d;
            txd_q      <= txd_d;
            tx_first_q <= tx_first_d;
        end
    end

    // Writes are suppressed while rst is held so bytes seen during reset never land.
    assign mem_we        = rx_valid && (state_q == ST_RX) && !rst;
    assign mem_waddr     = wr_cnt_q[ADDR_W-1:0];
    assign mem_wdata     = mem_we ? rx_data : 8'h00;
    assign mem_raddr     = rd_cnt_q[ADDR_W-1:0];
    assign tx_valid      = (state_q == ST_TX);
    assign tx_data       = tx_valid ? (tx_first_q ? mem_rdata : txd_q) : 8'h00;
    assign data_send_run = run_q;
    assign batch_done    = (state_q == ST_DONE);
    assign overrun       = ovr_q;
    assign batch_cnt     = bcnt_q;

endmodule

// File: tb/tb_uart_batch_ctrl.sv
// Bench for uart_batch_ctrl: directed scenarios plus randomized batches,
// checked every cycle against a queue-based model of the batch/echo rules.
module tb_uart_batch_ctrl;

    localparam int AW = 4;
    localparam int BL = 4;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [7:0]    mem_rdata;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic          data_send_run;
    logic          batch_done;
    logic          overrun;
    logic [15:0]   batch_cnt;

    uart_batch_ctrl #(.ADDR_W(AW), .BATCH_LEN(BL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .data_send_run(data_send_run), .batch_done(batch_done),
        .overrun(overrun), .batch_cnt(batch_cnt)
    );

    initial forever #5 clk = ~clk;

    // External 1R1W buffer with registered read
    logic [7:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    int total = 0;
    int bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_valid = 0;
    bit         m_collect, m_send, m_done, m_ovr;
    int         m_count, m_idle, m_gap, m_bcnt;
    logic [7:0] m_buf[$];
    logic [7:0] send_q[$];
    logic [7:0] log_q[$];
    int         acc_in_batch = 0;

    task automatic model_reset();
        m_collect = 1; m_send = 0; m_done = 0; m_ovr = 0;
        m_count = 0; m_idle = 0; m_gap = 0; m_bcnt = 0;
        m_buf.delete(); send_q.delete();
        acc_in_batch = 0;
    endtask

    task automatic model_close();
        m_collect = 0; m_send = 1; m_gap = 0;
        send_q = m_buf;
    endtask

    always @(negedge clk) begin
        bit exp_we, exp_txv;
        exp_we  = rx_valid && m_collect && !rst;
        exp_txv = m_send && (m_gap >= 1);
        if (m_valid) begin
            chk("mem_we", mem_we, exp_we);
            if (exp_we) begin
                chk("mem_waddr", mem_waddr, m_count % (1 << AW));
                chk("mem_wdata", mem_wdata, rx_data);
            end
            chk("tx_valid", tx_valid, exp_txv);
            if (exp_txv && send_q.size() > 0) chk("tx_data", tx_data, send_q[0]);
            chk("data_send_run", data_send_run, m_send);
            chk("batch_done", batch_done, m_done);
            chk("batch_cnt", batch_cnt, m_bcnt & 16'hFFFF);
            chk("overrun", overrun, m_ovr);
        end
        if (rst) begin
            model_reset();
            m_valid = 1;
        end else if (m_valid) begin
            if (rx_valid && !m_collect) m_ovr = 1;
            if (m_done) begin
                m_done = 0; m_bcnt++; m_collect = 1;
                m_count = 0; m_idle = 0; m_buf.delete();
                acc_in_batch = 0;
            end else if (m_collect) begin
                if (rx_valid) begin
                    m_buf.push_back(rx_data);
                    m_count++; m_idle = 0;
                    if (m_count == BL) model_close();
                end else if (m_count > 0) begin
                    m_idle++;
                    if (m_idle == TO) model_close();
                end
            end else if (m_send) begin
                if (exp_txv && tx_ready) begin
                    $display("tx byte %02h (batch %0d, index %0d)", tx_data, m_bcnt, acc_in_batch);
                    log_q.push_back(tx_data);
                    acc_in_batch++;
                    void'(send_q.pop_front());
                    if (send_q.size() == 0) begin
                        m_send = 0; m_done = 1;
                    end else begin
                        m_gap = 0;
                    end
                end else if (m_gap < 2) begin
                    m_gap++;
                end
            end
        end
    end

    // ---------------- tx_ready driver ----------------
    int ready_mode  = 0;   // 0: always ready, 1: random, 2: stall 2nd byte 5 cycles
    int stalls_done = 0;
    initial forever begin
        @(posedge clk); #1;
        if (ready_mode == 2) begin
            if (tx_valid && acc_in_batch == 1 && stalls_done < 5) begin
                tx_ready = 1'b0;
                stalls_done++;
            end else begin
                tx_ready = 1'b1;
            end
        end else begin
            stalls_done = 0;
            tx_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_done(input string name, input int budget, input bit poke);
        int n;
        n = 0;
        while (!batch_done && n < budget) begin
            if (poke && $urandom_range(0, 7) == 0) begin
                rx_valid = 1'b1; rx_data = 8'($urandom);
            end else begin
                rx_valid = 1'b0;
            end
            cyc();
            n++;
        end
        rx_valid = 1'b0;
        chk({name, "_done_seen"}, batch_done, 1'b1);
        cyc();
    endtask

    task automatic check_log(input string name, input int start, input logic [31:0] exp, input int n);
        chk({name, "_len"}, log_q.size() - start, n);
        for (int i = 0; i < n; i++) begin
            if (start + i < log_q.size())
                chk({name, "_byte"}, log_q[start + i], exp[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_we"}, mem_we, 1'b0);
        chk({name, "_waddr"}, mem_waddr, 0);
        chk({name, "_wdata"}, mem_wdata, 0);
        chk({name, "_raddr"}, mem_raddr, 0);
        chk({name, "_txv"}, tx_valid, 1'b0);
        chk({name, "_txd"}, tx_data, 0);
        chk({name, "_run"}, data_send_run, 1'b0);
        chk({name, "_done"}, batch_done, 1'b0);
        chk({name, "_ovr"}, overrun, 1'b0);
        chk({name, "_bcnt"}, batch_cnt, 0);
    endtask

    initial begin
        int st, n, len;

        // 1: reset with rx activity that must not be written
        rst = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        cyc(); cyc();
        rx_valid = 1'b0;
        cyc();
        rst = 1'b0;
        check_zero("rst");

        // 2: full batch, always ready
        st = log_q.size();
        send4(32'hA1A2A3A4);
        chk("s2_run_after_last", data_send_run, 1'b1);
        chk("s2_rd_no_valid", tx_valid, 1'b0);
        cyc();
        chk("s2_first_valid", tx_valid, 1'b1);
        chk("s2_first_data", tx_data, 8'hA1);
        wait_done("s2", 100, 0);
        check_log("s2", st, 32'hA1A2A3A4, 4);
        chk("s2_bcnt", batch_cnt, 1);

        // 3: stall on the second byte
        ready_mode = 2;
        st = log_q.size();
        send4(32'hB1B2B3B4);
        wait_done("s3", 100, 0);
        chk("s3_stalls", stalls_done, 5);
        ready_mode = 0;
        check_log("s3", st, 32'hB1B2B3B4, 4);
        chk("s3_bcnt", batch_cnt, 2);

        // 4a: partial batch flushed by idle timeout
        st = log_q.size();
        send_byte(8'h55); send_byte(8'h66);
        wait_done("s4a", 100, 0);
        check_log("s4a", st, 32'h00005566, 2);
        chk("s4a_bcnt", batch_cnt, 3);

        // 4b: byte on the 20th idle cycle wins over the flush
        st = log_q.size();
        send_byte(8'h55); send_byte(8'h66);
        repeat (19) cyc();
        rx_valid = 1'b1; rx_data = 8'h88;
        #1;
        chk("s4b_we", mem_we, 1'b1);
        chk("s4b_waddr", mem_waddr, 2);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("s4b_no_flush", data_send_run, 1'b0);
        send_byte(8'h99);
        wait_done("s4b", 100, 0);
        check_log("s4b", st, 32'h55668899, 4);

        // 5: byte during TX -> overrun, dropped
        send4(32'hC1C2C3C4);
        n = 0;
        while (!tx_valid && n < 50) begin cyc(); n++; end
        chk("s5_reach_tx", tx_valid, 1'b1);
        rx_valid = 1'b1; rx_data = 8'h77;
        #1;
        chk("s5_drop_we", mem_we, 1'b0);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        chk("s5_overrun", overrun, 1'b1);
        wait_done("s5a", 100, 0);
        st = log_q.size();
        send4(32'hD1D2D3D4);
        wait_done("s5b", 100, 0);
        check_log("s5b", st, 32'hD1D2D3D4, 4);
        chk("s5_overrun_sticky", overrun, 1'b1);

        // 6: reset mid-TX after two bytes
        send4(32'hE1E2E3E4);
        n = 0;
        while (!(acc_in_batch == 2 && tx_valid) && n < 50) begin cyc(); n++; end
        chk("s6_reach", acc_in_batch, 2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_zero("s6");
        st = log_q.size();
        send4(32'h01020304);
        wait_done("s6", 100, 0);
        check_log("s6", st, 32'h01020304, 4);
        chk("s6_bcnt", batch_cnt, 1);

        // Randomized batches: random lengths, gaps, ready stalls and overrun pokes
        ready_mode = 1;
        for (int b = 0; b < 12; b++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 4)) cyc();
                send_byte(8'($urandom));
            end
            wait_done("rnd", 400, 1);
        end
        ready_mode = 0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
